branch_resolver: RTL

- Consumer end of the branch-prediction interface.
- Captures each IF-stage prediction (target, predicted flag) into an in-flight queue that tracks the instruction down the pipeline.
- When the instruction reaches EX, compares the prediction with the actual outcome, then issues redirect/flush on mispredict and an update record back to the predictor table.
- Sits between the IF-side predictor and the EX-stage branch unit.

---
 rtl/bpu_pkg.sv | 34 +++
 rtl/pred_queue.sv | 73 +++++++
 rtl/branch_resolver.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/bpu_pkg.sv
// Shared types for the branch resolver: queued prediction entries, resolver
// FSM states, predictor update record and the mispredict rule.
package bpu_pkg;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] predict;
    logic        predicted;
  } pred_entry_t;

  typedef enum logic {
    IDLE,
    FLUSH
  } resolver_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic        hit;
  } upd_rec_t;

  function automatic logic is_mispredict(input logic        predicted,
                                         input logic [31:0] predict,
                                         input logic        is_branch,
                                         input logic        taken,
                                         input logic [31:0] target);
    return (predicted && !(is_branch && taken && (target == predict))) ||
           (!predicted && is_branch && taken);
  endfunction

endpackage

// File: rtl/pred_queue.sv
// In-flight prediction FIFO. A push on a full queue is accepted only when a
// pop happens in the same cycle; clear wins over both.
module pred_queue
  import bpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        push,
  input  logic        pop,
  input  logic        clear,
  input  pred_entry_t push_data,
  output pred_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  pred_entry_t    mem_q [DEPTH];
  pred_entry_t    mem_d [DEPTH];
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: matches EX outcomes against queued IF predictions and
// issues redirect/flush plus predictor updates. Optional: BRANCH_STATS_EN.
//
//   state | meaning
//   IDLE  | accepting pushes/pops, resolving at each pop
//   FLUSH | flush held after a mispredict, queue frozen
module branch_resolver
  import bpu_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_predict,
  input  logic        if_predicted,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_is_branch,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        upd_valid,
  output logic [31:0] upd_pc,
  output logic [31:0] upd_target,
  output logic        upd_taken,
  output logic        upd_hit,
  output logic        q_full,
  output logic        q_empty,
  output logic        err_order,
`ifdef BRANCH_STATS_EN
  output logic        err_overflow,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
`else
  output logic        err_overflow
`endif
);

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end

  resolver_state_t state_q, state_d;
  logic [FW-1:0]   cnt_q, cnt_d;
  logic            flush_q, flush_d;
  logic            redirect_q, redirect_d;
  logic [31:0]     redirect_pc_q, redirect_pc_d;
  logic            upd_valid_q, upd_valid_d;
  upd_rec_t        upd_q, upd_d;
  logic            err_order_q, err_order_d;
  logic            err_overflow_q, err_overflow_d;

  logic            push_req, pop_req, mispredict;
  pred_entry_t     head, res_entry, push_entry;
  logic [31:0]     correct_pc;

  assign push_req   = if_valid && !stall && (state_q == IDLE);
  assign pop_req    = ex_valid && !stall && (state_q == IDLE);
  assign push_entry = '{pc: if_pc, predict: if_predict, predicted: if_predicted};
  // An empty-queue pop resolves as if nothing had been predicted.
  assign res_entry  = q_empty ? '0 : head;
  assign mispredict = pop_req && is_mispredict(res_entry.predicted, res_entry.predict,
                                               ex_is_branch, ex_taken, ex_target);
  assign correct_pc = ex_taken ? ex_target : (ex_pc + PC_STEP);

  pred_queue #(.DEPTH(DEPTH)) u_queue (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push_req),
    .pop       (pop_req),
    .clear     (mispredict),
    .push_data (push_entry),
    .head      (head),
    .full      (q_full),
    .empty     (q_empty)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    flush_d        = flush_q;
    redirect_d     = 1'b0;
    redirect_pc_d  = redirect_pc_q;
    upd_valid_d    = pop_req && (ex_is_branch || res_entry.predicted);
    upd_d          = upd_q;
    err_order_d    = err_order_q ||
                     (pop_req && (q_empty || (head.pc != ex_pc)));
    err_overflow_d = err_overflow_q || (push_req && q_full && !pop_req);
    if (upd_valid_d) begin
      upd_d = '{pc: ex_pc, target: (ex_taken ? ex_target : 32'd0),
                taken: ex_taken, hit: !mispredict};
    end
    case (state_q)
      IDLE: begin
        if (mispredict) begin
          redirect_d    = 1'b1;
          redirect_pc_d = correct_pc;
          flush_d       = 1'b1;
          cnt_d         = FW'(FLUSH_CYCLES - 1);
          state_d       = FLUSH;
        end
      end
      FLUSH: begin
        if (cnt_q == '0) begin
          flush_d = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - FW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      flush_q        <= 1'b0;
      redirect_q     <= 1'b0;
      redirect_pc_q  <= '0;
      upd_valid_q    <= 1'b0;
      upd_q          <= '0;
      err_order_q    <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      flush_q        <= flush_d;
      redirect_q     <= redirect_d;
      redirect_pc_q  <= redirect_pc_d;
      upd_valid_q    <= upd_valid_d;
      upd_q          <= upd_d;
      err_order_q    <= err_order_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign redirect     = redirect_q;
  assign redirect_pc  = redirect_pc_q;
  assign flush        = flush_q;
  assign upd_valid    = upd_valid_q;
  assign upd_pc       = upd_q.pc;
  assign upd_target   = upd_q.target;
  assign upd_taken    = upd_q.taken;
  assign upd_hit      = upd_q.hit;
  assign err_order    = err_order_q;
  assign err_overflow = err_overflow_q;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] stat_br_q, stat_br_d;
  logic [CNT_W-1:0] stat_mp_q, stat_mp_d;

  // Counters stick at all-ones instead of wrapping.
  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (pop_req && ex_is_branch && (stat_br_q != '1)) stat_br_d = stat_br_q + CNT_W'(1);
    if (mispredict && (stat_mp_q != '1))              stat_mp_d = stat_mp_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

endmodule
